// File: rtl/pool_window_gen.sv
// rtl/pool_window_gen.sv - streaming 2x2 stride-2 window former with one-row line buffer
module pool_window_gen #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    localparam int OCW   = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1,
    localparam int ORW   = (IMG_H / 2 > 1) ? $clog2(IMG_H / 2) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_c,
    output logic [DATA_W-1:0] out_d,
    output logic [ORW-1:0]    out_row,
    output logic [OCW-1:0]    out_col,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    if (IMG_W < 2 || (IMG_W % 2) != 0) begin : g_bad_img_w
        $error("pool_window_gen: IMG_W must be even and >= 2");
    end
    if (IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_img_h
        $error("pool_window_gen: IMG_H must be even and >= 2");
    end

    logic [CW-1:0]     col_cnt;
    logic [RW-1:0]     row_cnt;
    logic [DATA_W-1:0] line_buf [IMG_W];
    logic [DATA_W-1:0] hold_reg;
    logic              accept;
    logic              col_last;
    logic              row_last;
    logic              form;
    logic [CW-1:0]     col_prev;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_last = (col_cnt == CW'(IMG_W - 1));
    assign row_last = (row_cnt == RW'(IMG_H - 1));
    // A window completes on the odd-row, odd-column pixel (its d tap).
    assign form     = accept && row_cnt[0] && col_cnt[0];
    assign col_prev = col_cnt - CW'(1);

    always_ff @(posedge clk) begin
        if (accept && !row_cnt[0]) begin
            line_buf[col_cnt] <= in_data;
        end
        if (accept && row_cnt[0] && !col_cnt[0]) begin
            hold_reg <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
            out_d     <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            if (accept) begin
                if (col_last) begin
                    col_cnt <= '0;
                    row_cnt <= row_last ? '0 : row_cnt + RW'(1);
                end else begin
                    col_cnt <= col_cnt + CW'(1);
                end
            end
            // A new window overwrites the register even while the old one drains.
            if (form) begin
                out_a     <= line_buf[col_prev];
                out_b     <= line_buf[col_cnt];
                out_c     <= hold_reg;
                out_d     <= in_data;
                out_row   <= ORW'(row_cnt >> 1);
                out_col   <= OCW'(col_cnt >> 1);
                out_last  <= row_last && col_last;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool_window_gen.sv
// tb/tb_pool_window_gen.sv - directed and randomised checks of pool_window_gen
module tb_pool_window_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_a, out_b, out_c, out_d;
    logic [3:0]  out_row, out_col;
    logic        out_valid, out_ready, out_last;

    logic [15:0] v_in_data;
    logic        v_in_valid, v_in_ready;
    logic [15:0] v_out_a, v_out_b, v_out_c, v_out_d;
    logic [0:0]  v_out_row, v_out_col;
    logic        v_out_valid, v_out_ready, v_out_last;

    pool_window_gen #(.DATA_W(16), .IMG_W(28), .IMG_H(28)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .out_row(out_row), .out_col(out_col), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    pool_window_gen #(.DATA_W(16), .IMG_W(4), .IMG_H(2)) dut_small (
        .clk(clk), .rst(rst), .in_data(v_in_data), .in_valid(v_in_valid), .in_ready(v_in_ready),
        .out_a(v_out_a), .out_b(v_out_b), .out_c(v_out_c), .out_d(v_out_d),
        .out_row(v_out_row), .out_col(v_out_col), .out_valid(v_out_valid),
        .out_ready(v_out_ready), .out_last(v_out_last)
    );

    typedef struct {
        logic [15:0] a, b, c, d;
        int          row, col;
        logic        last;
    } win_t;

    win_t got[$];
    win_t vgot[$];
    int   checks = 0;
    int   errors = 0;
    logic acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [15:0] dat, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_data   = dat;
        out_ready = r;
        #1;
        if (out_valid && out_ready)
            got.push_back('{out_a, out_b, out_c, out_d, int'(out_row), int'(out_col), out_last});
        acc = in_valid && in_ready;
    endtask

    task automatic vcycle(input logic v, input logic [15:0] dat);
        @(negedge clk);
        v_in_valid  = v;
        v_in_data   = dat;
        v_out_ready = 1'b1;
        #1;
        if (v_out_valid && v_out_ready)
            vgot.push_back('{v_out_a, v_out_b, v_out_c, v_out_d, int'(v_out_row), int'(v_out_col), v_out_last});
    endtask

    // Pixel idx of a multi-frame stream: frame f carries values f*1000 + row*28 + col.
    task automatic feed(input int start, input int n, input int vprob, input int rprob);
        int idx    = start;
        int budget = n * 8 + 100;
        while (idx < start + n && budget > 0) begin
            cycle(($urandom_range(99) < vprob), 16'((idx / 784) * 1000 + idx % 784),
                  ($urandom_range(99) < rprob));
            if (acc) idx++;
            budget--;
        end
        check("feed_done", idx, start + n);
    endtask

    task automatic drain(input int k);
        repeat (k) cycle(1'b0, 16'd0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        v_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
    endtask

    task automatic verify(input int base, input int off, input string tag);
        int ea;
        if (got.size() >= base + 196) begin
            for (int k = 0; k < 196; k++) begin
                ea = off + 56 * (k / 14) + 2 * (k % 14);
                check({tag, "_taps"}, {got[base+k].a, got[base+k].b, got[base+k].c, got[base+k].d},
                      {16'(ea), 16'(ea + 1), 16'(ea + 28), 16'(ea + 29)});
                check({tag, "_pos"}, got[base+k].row * 1000 + got[base+k].col * 10 + int'(got[base+k].last),
                      (k / 14) * 1000 + (k % 14) * 10 + ((k == 195) ? 1 : 0));
            end
        end else begin
            check({tag, "_count"}, got.size(), base + 196);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        v_in_valid = 1'b0; v_in_data = '0; v_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_last", out_last, 0);
        check("rst_taps", {out_a, out_b, out_c, out_d}, 64'd0);
        check("rst_row_col", {out_row, out_col}, 8'd0);

        // Two back-to-back frames, continuous stream, second offset by 1000.
        feed(0, 1568, 100, 100);
        drain(3);
        check("b2b_count", got.size(), 392);
        verify(0, 0, "f1");
        verify(196, 1000, "f2");

        // Backpressure on the first window.
        do_reset();
        got.delete();
        feed(0, 30, 100, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 16'd30, 1'b0);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_taps", {out_a, out_b, out_c, out_d}, {16'd0, 16'd1, 16'd28, 16'd29});
            check("bp_no_accept", acc, 0);
        end
        feed(30, 754, 100, 100);
        drain(3);
        check("bp_count", got.size(), 196);
        verify(0, 0, "bp");

        // Random valid/ready over three frames.
        do_reset();
        got.delete();
        feed(0, 2352, 50, 50);
        drain(4);
        check("rnd_count", got.size(), 588);
        verify(0, 0, "r1");
        verify(196, 1000, "r2");
        verify(392, 2000, "r3");

        // Reset mid-frame then restart.
        do_reset();
        got.delete();
        feed(0, 100, 100, 100);
        do_reset();
        got.delete();
        for (int i = 0; i < 29; i++) begin
            cycle(1'b1, 16'(i), 1'b1);
            check("post_rst_ov", out_valid, 0);
        end
        feed(29, 755, 100, 100);
        drain(3);
        check("mid_rst_count", got.size(), 196);
        verify(0, 0, "mr");

        // Small variant 4x2.
        for (int i = 0; i < 8; i++) vcycle(1'b1, 16'(i));
        repeat (3) vcycle(1'b0, 16'd0);
        check("var_count", vgot.size(), 2);
        if (vgot.size() == 2) begin
            check("var_w0_taps", {vgot[0].a, vgot[0].b, vgot[0].c, vgot[0].d}, {16'd0, 16'd1, 16'd4, 16'd5});
            check("var_w0_pos", vgot[0].row * 100 + vgot[0].col * 10 + int'(vgot[0].last), 0);
            check("var_w1_taps", {vgot[1].a, vgot[1].b, vgot[1].c, vgot[1].d}, {16'd2, 16'd3, 16'd6, 16'd7});
            check("var_w1_pos", vgot[1].row * 100 + vgot[1].col * 10 + int'(vgot[1].last), 11);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
Streaming 2x2 window former placed directly upstream of the 2x2 average-pool array. It accepts one feature-map pixel per handshake in raster order (row-major, row 0 first) from the convolution stage and buffers one image row. It emits each non-overlapping 2x2 window (stride 2) as four taps a/b/c/d, matching the pool unit's operand order: a=(2r,2c), b=(2r,2c+1), c=(2r+1,2c), d=(2r+1,2c+1).

Parameters:
DATA_W, 16, pixel width in bits (signed/unsigned agnostic; data is passed through unmodified)
IMG_W, 28, input image width in pixels; must be even and >=2
IMG_H, 28, input image height in pixels; must be even and >=2

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_data  input  DATA_W  incoming pixel
in_valid  input  1  in_data is valid
in_ready  output  1  block accepts a pixel this cycle
out_a  output  DATA_W  window tap (2r,2c)
out_b  output  DATA_W  window tap (2r,2c+1)
out_c  output  DATA_W  window tap (2r+1,2c)
out_d  output  DATA_W  window tap (2r+1,2c+1)
out_row  output  clog2(IMG_H/2)  window row index r
out_col  output  clog2(IMG_W/2)  window column index c
out_valid  output  1  window outputs are valid
out_ready  input  1  downstream accepts the window
out_last  output  1  window is the last of the frame, at r=IMG_H/2-1 and c=IMG_W/2-1

Behaviour:
- Accept: a pixel is taken on a rising edge when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational and gives a single output register with pass-through on the ready path.
- Counters: col_cnt runs 0..IMG_W-1 and row_cnt runs 0..IMG_H-1. Both advance only on accept.
  - col_cnt wraps to 0 at IMG_W-1 and increments row_cnt.
  - row_cnt wraps to 0 at IMG_H-1 at the end of the row, so the next frame starts with no idle cycle.
- Even row (row_cnt[0]=0): each pixel is written to line_buf[col_cnt]. Depth is IMG_W, width is DATA_W. No output is produced.
- Odd row, even col: the pixel is stored in hold_reg. No output is produced.
- Odd row, odd col: on the accept edge, register the outputs and set out_valid=1:
  - out_a=line_buf[col_cnt-1], out_b=line_buf[col_cnt], out_c=hold_reg, out_d=in_data
  - out_row=row_cnt>>1, out_col=col_cnt>>1
  - out_last=(row_cnt==IMG_H-1 && col_cnt==IMG_W-1)
- Latency: one cycle from acceptance of the d pixel to out_valid high.
- Output handshake:
  - out_valid stays high, with all out_* held stable, until out_valid && out_ready.
  - On a transfer with no new window formed in the same cycle, out_valid clears next cycle.
  - A window completing in the same cycle as an output transfer replaces the register, giving back-to-back windows with no bubble.
- Backpressure: while out_valid && !out_ready, in_ready=0. No pixel is accepted or lost, and the counters freeze.
- in_valid gaps: there is no timeout. Counters and buffers hold state indefinitely.
- Line buffer: single write port and two read ports for columns col_cnt-1 and col_cnt. Either registers or inferred RAM is acceptable, provided combinational reads meet the one-cycle latency above.
- Reset: rst=1 on a clock edge clears col_cnt, row_cnt, out_valid and out_last, and drives out_a..out_d, out_row and out_col to 0.
  - line_buf and hold_reg need no reset.
  - Reset mid-frame discards the partial frame. The first pixel after reset is treated as (0,0).
- Elaboration fails if IMG_W or IMG_H is odd or <2.

Test Plan:
1. Full frame, 28x28, pixel value=row*28+col, in_valid=1, out_ready=1.
   - Exactly 196 windows are produced.
   - First window: a=0, b=1, c=28, d=29, row=0, col=0, out_last=0.
   - Last window: a=754, b=755, c=782, d=783, row=13, col=13, out_last=1 (the only out_last pulse).
2. Backpressure: hold out_ready=0 for 5 cycles when the first window appears.
   - out_valid stays 1 and the outputs remain a=0, b=1, c=28, d=29.
   - in_ready=0 throughout.
   - After release, the following window is a=2, b=3, c=30, d=31 with no pixel dropped.
3. Random in_valid (50%) and random out_ready (50%) over 3 frames.
   - Scoreboard sees window (r,c) taps at indices (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
   - 588 windows in total, with out_last on every 196th.
4. Back-to-back frames, continuous stream.
   - Frame 2 pixel values are offset by 1000.
   - Frame 2 first window is a=1000, b=1001, c=1028, d=1029, with row/col back at 0 immediately after frame 1's out_last.
5. Reset mid-frame: assert rst for 1 cycle after 100 pixels, then restart the frame.
   - The next output is a=0, b=1, c=28, d=29 at row=0, col=0.
   - out_valid=0 during and after the rst cycle until the new window forms.
6. Parameter variant IMG_W=4, IMG_H=2, pixels 0..7.
   - Exactly 2 windows: (0,1,4,5) with out_col=0, and (2,3,6,7) with out_col=1 and out_last=1.
